// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: a small input FIFO feeds an IDLE/SHIFT FSM that
// emits each word as DATA_W contiguous serial bits, back to back when words are queued.
module bit_serializer #(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              frame_done,
  output logic              busy,
  output logic              dbg_state_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered occupancy, never on in_valid.
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]    count_q;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dout_q, dout_d;
  logic                dv_q, dv_d;
  logic                fd_q, fd_d;
  logic                full, empty, push, pop;
  logic [DATA_W-1:0]   head;

  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  assign full     = (count_q == OCC_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + OCC_W'(1);
      else if (pop && !push) count_q <= count_q - OCC_W'(1);
    end
  end

  // A load presents the head word's first bit immediately; cnt then counts the bits still to come.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    dout_d  = 1'b0;
    dv_d    = 1'b0;
    fd_d    = 1'b0;
    pop     = 1'b0;
    if ((state_q == IDLE || cnt_q == '0) && !empty) begin
      pop     = 1'b1;
      state_d = SHIFT;
      dout_d  = head_bit(head);
      sh_d    = drop_head(head);
      cnt_d   = CNT_W'(DATA_W - 1);
      dv_d    = 1'b1;
      fd_d    = (DATA_W == 1);
    end else if (state_q == SHIFT && cnt_q != '0) begin
      dout_d = head_bit(sh_q);
      sh_d   = drop_head(sh_q);
      cnt_d  = cnt_q - CNT_W'(1);
      dv_d   = 1'b1;
      fd_d   = (cnt_q == CNT_W'(1));
    end else if (state_q == SHIFT) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      dv_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      fd_q    <= fd_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dv_q;
  assign frame_done  = fd_q;
  assign busy        = (state_q == SHIFT) || !empty;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share stimulus and
// are compared cycle by cycle against a word/bit-queue reference model.
module tb_bit_serializer;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic rdy_m, dout_m, dv_m, fd_m, busy_m, st_m;
  logic rdy_l, dout_l, dv_l, fd_l, busy_l, st_l;

  always #5 clk = ~clk;

  bit_serializer #(.DATA_W(DATA_W), .MSB_FIRST(1), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
    .dout(dout_m), .dout_valid(dv_m), .frame_done(fd_m), .busy(busy_m), .dbg_state_o(st_m)
  );

  bit_serializer #(.DATA_W(DATA_W), .MSB_FIRST(0), .FIFO_DEPTH(FIFO_DEPTH)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
    .dout(dout_l), .dout_valid(dv_l), .frame_done(fd_l), .busy(busy_l), .dbg_state_o(st_l)
  );

  // Reference model: buffered words plus the bit sequences of the word on the wire.
  logic [DATA_W-1:0] exp_q[$];
  logic              cur_m[$];
  logic              cur_l[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        accepted;
  logic [31:0] cap_m, cap_l, fd_mask;
  int          nb_m, nb_l, runs, stall_cnt;
  logic        prev_dv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    cur_m.delete();
    cur_l.delete();
  endtask

  task automatic model_edge(input logic push, input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] nw;
    if (cur_m.size() > 0) begin
      void'(cur_m.pop_front());
      void'(cur_l.pop_front());
    end
    if (cur_m.size() == 0 && exp_q.size() > 0) begin
      nw = exp_q.pop_front();
      for (int i = 0; i < DATA_W; i++) begin
        cur_m.push_back(nw[DATA_W-1-i]);
        cur_l.push_back(nw[i]);
      end
    end
    if (push) exp_q.push_back(w);
  endtask

  task automatic cap_clear();
    cap_m = '0; cap_l = '0; fd_mask = '0;
    nb_m = 0; nb_l = 0; runs = 0; stall_cnt = 0; prev_dv = 1'b0;
  endtask

  task automatic check_outputs();
    logic ev;
    ev = (cur_m.size() > 0);
    check("m_valid", dv_m, ev);
    check("m_dout", dout_m, ev ? cur_m[0] : 1'b0);
    check("m_frame_done", fd_m, cur_m.size() == 1);
    check("m_state", st_m, ev);
    check("l_valid", dv_l, ev);
    check("l_dout", dout_l, ev ? cur_l[0] : 1'b0);
    check("l_frame_done", fd_l, cur_l.size() == 1);
    check("busy", busy_m, ev || exp_q.size() > 0);
    check("l_busy", busy_l, ev || exp_q.size() > 0);
    check("in_ready", rdy_m, exp_q.size() < FIFO_DEPTH);
    check("l_in_ready", rdy_l, exp_q.size() < FIFO_DEPTH);
    if (dv_m) begin
      cap_m = {cap_m[30:0], dout_m};
      nb_m++;
      if (fd_m && nb_m <= 32) fd_mask[nb_m-1] = 1'b1;
      if (!prev_dv) runs++;
    end
    if (dv_l) begin
      cap_l = {cap_l[30:0], dout_l};
      nb_l++;
    end
    if (!rdy_m) stall_cnt++;
    prev_dv = dv_m;
  endtask

  task automatic tick();
    logic              p;
    logic [DATA_W-1:0] d;
    @(negedge clk);
    check_outputs();
    p = in_valid && rdy_m && !rst;
    d = in_data;
    @(posedge clk);
    if (rst) model_clear();
    else model_edge(p, d);
    accepted = p;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    accepted = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (accepted) break;
    end
    check("push_accepted", accepted, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = DATA_W'($urandom);
    #1;
    check("rst_valid", dv_m, 1'b0);
    check("rst_dout", dout_m, 1'b0);
    check("rst_frame_done", fd_m, 1'b0);
    check("rst_busy", busy_m, 1'b0);
    check("rst_in_ready", rdy_m, 1'b1);
    check("rst_l_valid", dv_l, 1'b0);
    model_clear();
    idle(n);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    cap_clear();
    do_reset(3);

    // Single word, both bit orders
    cap_clear();
    push_word(8'hA9);
    idle(12);
    check("a9_msb_bits", cap_m[7:0], 8'hA9);
    check("a9_lsb_bits", cap_l[7:0], 8'h95);
    check("a9_bit_count", nb_m, 8);
    check("a9_frame_pos", fd_mask, 32'h80);

    // Back-to-back words
    cap_clear();
    push_word(8'hA9);
    push_word(8'h55);
    idle(20);
    check("b2b_bits", cap_m[15:0], 16'hA955);
    check("b2b_bit_count", nb_m, 16);
    check("b2b_runs", runs, 1);
    check("b2b_frame_pos", fd_mask, 32'h8080);

    // Buffer fills while the first word shifts
    cap_clear();
    push_word(8'hA9);
    push_word(8'h3C);
    push_word(8'hC3);
    push_word(8'h5A);
    idle(40);
    check("full_bits", cap_m, 32'hA93CC35A);
    check("full_bit_count", nb_m, 32);
    check("full_runs", runs, 1);
    check("full_stall_seen", stall_cnt != 0, 1'b1);

    // Reset in the middle of a frame with a word buffered
    cap_clear();
    push_word(8'hA9);
    push_word(8'hFF);
    for (int i = 0; i < 20 && nb_m < 3; i++) tick();
    check("mid_bits_before_rst", nb_m, 3);
    do_reset(2);
    cap_clear();
    idle(20);
    check("post_rst_m_bits", nb_m, 0);
    check("post_rst_l_bits", nb_l, 0);

    // Idle gap between two frames
    cap_clear();
    push_word(8'h0F);
    idle(20);
    check("gap_busy", busy_m, 1'b0);
    push_word(8'hF0);
    idle(12);
    check("gap_bits", cap_m[15:0], 16'h0FF0);
    check("gap_bit_count", nb_m, 16);
    check("gap_runs", runs, 2);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = DATA_W'($urandom);
      tick();
      if ($urandom_range(0, 99) == 0) do_reset(1);
    end
    in_valid = 1'b0;
    idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8, giving the parallel word width in bits.
REQ-002 The block SHALL take parameter MSB_FIRST, default 1; 1 sends bit DATA_W-1 first, 0 sends bit 0 first.
REQ-003 The block SHALL take parameter FIFO_DEPTH, default 2, giving the number of entries in the input buffer (power of two, at least 2).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 Port in_data, input, DATA_W bits: parallel word to serialize.
REQ-008 Port in_valid, input, 1 bit: in_data is valid.
REQ-009 Port in_ready, output, 1 bit: the buffer can accept a word.
REQ-010 Port dout, output, 1 bit: serial bit stream, which drives the sequence detector din.
REQ-011 Port dout_valid, output, 1 bit: dout carries a payload bit this cycle.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse on the last bit of each word.
REQ-013 Port busy, output, 1 bit: high when the FSM is in SHIFT or the buffer is non-empty.

Function
REQ-014 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_valid=1 with in_ready=0 is ignored, with no data loss.
REQ-015 in_ready SHALL equal NOT full, derived combinationally from the registered occupancy count.
REQ-016 The input buffer SHALL be FIFO-ordered, with a wrapping read pointer, a wrapping write pointer and an occupancy count from 0 to FIFO_DEPTH.
REQ-017 A simultaneous push and pop SHALL leave the count unchanged; pop on empty SHALL never occur.
REQ-018 The FSM SHALL have two states, IDLE and SHIFT, with registered outputs.
REQ-019 IDLE with the buffer non-empty: pop the head into the shift register, load the bit counter with DATA_W-1, then go to SHIFT.
REQ-020 IDLE with the buffer empty: stay in IDLE.
REQ-021 SHIFT with counter > 0: present the next bit, then decrement the counter.
REQ-022 SHIFT with counter = 0 and the buffer non-empty: pop and reload in the same cycle, so the next word's first bit follows with no gap.
REQ-023 SHIFT with counter = 0 and the buffer empty: go to IDLE.
REQ-024 Latency: a word accepted at edge N into an empty, idle block SHALL put its first bit on dout/dout_valid after edge N+1.
REQ-025 Each word SHALL occupy exactly DATA_W consecutive dout_valid cycles.
REQ-026 dout SHALL be 0 whenever dout_valid=0.
REQ-027 frame_done SHALL be high exactly in the cycle that carries a word's final bit, coincident with dout_valid=1.
REQ-028 Bit order SHALL follow MSB_FIRST; the shift register shifts toward the output end with 0 fill.
REQ-029 The bit counter SHALL be ceil(log2(DATA_W)) bits wide and SHALL never underflow.
REQ-030 The block SHALL have no backpressure from downstream; dout is consumed every cycle.

Reset
REQ-031 While rst=1, and immediately on its assertion: state=IDLE, count=0, pointers=0, shift register=0, bit counter=0, dout=0, dout_valid=0, frame_done=0, busy=0.
REQ-032 in_ready SHALL be 1 during reset, since the buffer is empty, but no transfer SHALL occur while rst=1.
REQ-033 Reset mid-frame SHALL discard the partial word and all buffered words; after release the block is in IDLE and emits no residual bits.

Verification
REQ-034 Single word, MSB_FIRST=1: push 8'hA9 once into an idle block -> dout = 1,0,1,0,1,0,0,1 over 8 consecutive dout_valid cycles, with frame_done on the 8th cycle.
REQ-035 Back-to-back: push 8'hA9 then 8'h55 on consecutive edges -> 16 contiguous dout_valid cycles 10101001 01010101, and frame_done pulses on cycles 8 and 16.
REQ-036 Buffer full: push 3 words while the first is shifting, with FIFO_DEPTH=2 -> in_ready drops to 0 after the buffer fills and rises when the next pop occurs; all words come out in order with none lost.
REQ-037 Reset mid-frame: assert rst after 3 bits of 8'hA9 with 8'hFF buffered -> dout_valid=0 immediately, and no bits of either word appear after release.
REQ-038 LSB order: with MSB_FIRST=0, push 8'hA9 -> dout = 1,0,0,1,0,1,0,1.
REQ-039 Idle gap: push 8'h0F, wait 20 cycles, then push 8'hF0 -> dout_valid is low between the two frames, dout=0 during the gap, and busy=0 during the gap.
